servo_pos_ramp: RTL and testbench



---
 rtl/servo_pkg.sv | 33 +++
 rtl/servo_frame_timer.sv | 41 ++++
 rtl/servo_pos_ramp.sv | 119 +++++++++++
 tb/tb_servo_pos_ramp.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// Shared servo definitions: register map, default pulse limits and the ramp state encoding.
// Also used by the PWM drive stage and by the software headers.
package servo_pkg;

    localparam logic [1:0] REG_TARGET  = 2'd0;
    localparam logic [1:0] REG_STEP    = 2'd1;
    localparam logic [1:0] REG_CURRENT = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    localparam int unsigned DEF_MIN_PULSE    = 32'd50000;
    localparam int unsigned DEF_MAX_PULSE    = 32'd100000;
    localparam int unsigned DEF_CENTER_PULSE = 32'd75000;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RAMP = 1'b1
    } servo_state_e;

    function automatic logic [31:0] clamp_pulse(
        input logic [31:0] value,
        input logic [31:0] lo,
        input logic [31:0] hi
    );
        if (value < lo) begin
            return lo;
        end else if (value > hi) begin
            return hi;
        end else begin
            return value;
        end
    endfunction

endpackage

// File: rtl/servo_frame_timer.sv
// Free-running frame counter; tick_o pulses for one clock in the last cycle of every frame.
// Reusable by any frame-synchronous servo logic.
module servo_frame_timer #(
    parameter int unsigned FRAME_CYCLES = 32'd1000000
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);

    localparam int unsigned CNT_W = (FRAME_CYCLES > 32'd1) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_CYCLES - 32'd1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             tick_q;

    // Next count with wrap at the frame boundary.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Tick is registered from the next count, so it is high exactly while the counter holds LAST.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= (cnt_d == LAST);
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/servo_pos_ramp.sv
// Slew-rate limiter feeding the servo PWM stage: software sets a clamped target and a step,
// and the live pulse width walks one step toward the target once per frame.
module servo_pos_ramp
    import servo_pkg::*;
#(
    parameter int unsigned MIN_PULSE    = DEF_MIN_PULSE,
    parameter int unsigned MAX_PULSE    = DEF_MAX_PULSE,
    parameter int unsigned CENTER_PULSE = DEF_CENTER_PULSE,
    parameter int unsigned FRAME_CYCLES = 32'd1000000,
    parameter int unsigned DEFAULT_STEP = 32'd500
) (
    input  logic        clock_clk,
    input  logic        reset,
    input  logic [1:0]  avs_address,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    output logic [31:0] pulse_time,
    output logic        busy,
    output logic        frame_tick
);

    localparam logic [31:0] MIN_P    = 32'(MIN_PULSE);
    localparam logic [31:0] MAX_P    = 32'(MAX_PULSE);
    localparam logic [31:0] CENTER_P = 32'(CENTER_PULSE);
    localparam logic [23:0] STEP_RST = 24'(DEFAULT_STEP);

    servo_state_e state_q, state_d;
    logic [31:0]  target_q, target_d;
    logic [23:0]  step_q, step_d;
    logic [31:0]  pulse_q, pulse_d;
    logic [31:0]  rdata_q, rdata_d;
    logic         busy_q;
    logic         tick_s;
    logic [31:0]  diff_s;
    logic [31:0]  step32_s;

    servo_frame_timer #(.FRAME_CYCLES(FRAME_CYCLES)) u_timer (
        .clk_i  (clock_clk),
        .rst_i  (reset),
        .tick_o (tick_s)
    );

    assign step32_s = {8'd0, step_q};
    assign diff_s   = (target_q >= pulse_q) ? (target_q - pulse_q) : (pulse_q - target_q);

    // Register writes and the per-frame step; the tick uses the values held before any same-cycle write.
    always_comb begin
        target_d = target_q;
        step_d   = step_q;
        pulse_d  = pulse_q;
        if (avs_write && (avs_address == REG_TARGET)) begin
            target_d = clamp_pulse(avs_writedata, MIN_P, MAX_P);
        end else if (avs_write && (avs_address == REG_STEP)) begin
            step_d = avs_writedata[23:0];
        end else begin
            target_d = target_q;
        end
        case (state_q)
            ST_IDLE: pulse_d = pulse_q;
            ST_RAMP: begin
                if (!tick_s) begin
                    pulse_d = pulse_q;
                end else if ((step_q == 24'd0) || (diff_s <= step32_s)) begin
                    pulse_d = target_q;
                end else if (target_q > pulse_q) begin
                    pulse_d = pulse_q + step32_s;
                end else begin
                    pulse_d = pulse_q - step32_s;
                end
            end
            default: pulse_d = pulse_q;
        endcase
        // A write landing on the final tick can leave a fresh gap, which keeps us in RAMP.
        state_d = (target_d != pulse_d) ? ST_RAMP : ST_IDLE;
    end

    // Read mux; a simultaneous write is not yet visible, so the pre-write value is returned.
    always_comb begin
        rdata_d = rdata_q;
        if (avs_read) begin
            case (avs_address)
                REG_TARGET:  rdata_d = target_q;
                REG_STEP:    rdata_d = step32_s;
                REG_CURRENT: rdata_d = pulse_q;
                REG_STATUS:  rdata_d = {31'd0, busy_q};
                default:     rdata_d = 32'd0;
            endcase
        end else begin
            rdata_d = rdata_q;
        end
    end

    // State, registers and registered outputs.
    always_ff @(posedge clock_clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            target_q <= CENTER_P;
            step_q   <= STEP_RST;
            pulse_q  <= CENTER_P;
            rdata_q  <= 32'd0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            step_q   <= step_d;
            pulse_q  <= pulse_d;
            rdata_q  <= rdata_d;
            busy_q   <= (state_q == ST_RAMP);
        end
    end

    assign avs_readdata = rdata_q;
    assign pulse_time   = pulse_q;
    assign busy         = busy_q;
    assign frame_tick   = tick_s;

endmodule

// File: tb/tb_servo_pos_ramp.sv
// Directed bench for servo_pos_ramp with a read scoreboard: expected read data is queued at
// issue time and a monitor compares it when the read data becomes valid one cycle later.
module tb_servo_pos_ramp;

    localparam int unsigned FC = 32'd20;

    logic        clock_clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  avs_address = 2'd0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = 32'd0;
    logic        avs_read = 1'b0;
    logic [31:0] avs_readdata;
    logic [31:0] pulse_time;
    logic        busy;
    logic        frame_tick;

    int n_checks = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];

    servo_pos_ramp #(.FRAME_CYCLES(FC)) dut (
        .clock_clk     (clock_clk),
        .reset         (reset),
        .avs_address   (avs_address),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_read      (avs_read),
        .avs_readdata  (avs_readdata),
        .pulse_time    (pulse_time),
        .busy          (busy),
        .frame_tick    (frame_tick)
    );

    always #5 clock_clk = ~clock_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: a read strobe seen at a rising edge yields data valid by the following falling edge.
    always begin
        logic rd_seen;
        @(posedge clock_clk);
        rd_seen = avs_read;
        @(negedge clock_clk);
        if (rd_seen) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_read: got %0d expected no read", avs_readdata);
            end else begin
                check(name_q.pop_front(), avs_readdata, exp_q.pop_front());
            end
        end
    end

    task automatic do_reset();
        @(posedge clock_clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clock_clk);
        #1 reset = 1'b0;
    endtask

    task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
        @(posedge clock_clk); #1;
        avs_address = addr; avs_writedata = data; avs_write = 1'b1;
        @(posedge clock_clk); #1;
        avs_write = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] addr, input logic [31:0] exp, input string name);
        @(posedge clock_clk); #1;
        exp_q.push_back(exp);
        name_q.push_back(name);
        avs_address = addr; avs_read = 1'b1;
        @(posedge clock_clk); #1;
        avs_read = 1'b0;
    endtask

    // Waits for the next frame tick and returns just after the edge that applies it; an optional
    // TARGET write is issued in the tick cycle itself.
    task automatic wait_tick(input bit coll, input logic [31:0] coll_data);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 3 * FC; i++) begin
            @(negedge clock_clk);
            if (frame_tick) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            n_checks++;
            n_fail++;
            $display("FAIL tick_timeout: got no frame_tick expected one within %0d cycles", 3 * FC);
        end
        if (coll) begin
            avs_address = 2'd0; avs_writedata = coll_data; avs_write = 1'b1;
        end
        @(posedge clock_clk); #1;
        avs_write = 1'b0;
    endtask

    initial begin
        logic [31:0] seq5 [4];
        seq5[0] = 32'd74700; seq5[1] = 32'd74400; seq5[2] = 32'd74100; seq5[3] = 32'd74000;

        // Reset values
        do_reset();
        @(negedge clock_clk);
        check("rst_pulse", pulse_time, 32'd75000);
        check("rst_busy", {31'd0, busy}, 32'd0);
        bus_read(2'd0, 32'd75000, "rst_target");
        bus_read(2'd1, 32'd500, "rst_step");
        bus_read(2'd2, 32'd75000, "rst_current");
        bus_read(2'd3, 32'd0, "rst_status");

        // Ramp up by two steps
        do_reset();
        bus_write(2'd0, 32'd76000);
        @(negedge clock_clk); @(negedge clock_clk);
        check("ramp_busy_rise", {31'd0, busy}, 32'd1);
        wait_tick(1'b0, 32'd0);
        bus_read(2'd2, 32'd75500, "ramp_step1");
        check("ramp_busy_mid", {31'd0, busy}, 32'd1);
        wait_tick(1'b0, 32'd0);
        bus_read(2'd2, 32'd76000, "ramp_step2");
        bus_read(2'd3, 32'd0, "ramp_busy_fall");

        // Clamping of the target
        do_reset();
        bus_write(2'd0, 32'd10);
        bus_read(2'd0, 32'd50000, "clamp_low");
        bus_write(2'd0, 32'd200000);
        bus_read(2'd0, 32'd100000, "clamp_high");
        bus_write(2'd1, 32'hFF00_0123);
        bus_read(2'd1, 32'h0000_0123, "step_upper_ignored");
        bus_write(2'd2, 32'd1234);
        bus_read(2'd2, 32'd75000, "current_ro");

        // STEP = 0 jumps in one tick
        do_reset();
        bus_write(2'd1, 32'd0);
        bus_write(2'd0, 32'd60000);
        @(negedge clock_clk);
        check("jump_before_tick", pulse_time, 32'd75000);
        wait_tick(1'b0, 32'd0);
        @(negedge clock_clk);
        check("jump_after_tick", pulse_time, 32'd60000);
        bus_read(2'd2, 32'd60000, "jump_current");

        // Final partial step
        do_reset();
        bus_write(2'd1, 32'd300);
        bus_write(2'd0, 32'd74000);
        for (int i = 0; i < 4; i++) begin
            wait_tick(1'b0, 32'd0);
            bus_read(2'd2, seq5[i], $sformatf("partial_step%0d", i));
        end
        bus_read(2'd3, 32'd0, "partial_done");

        // Writes coincident with frame_tick, in IDLE and during a ramp
        do_reset();
        wait_tick(1'b1, 32'd76000);
        @(negedge clock_clk);
        check("coll_idle_tick", pulse_time, 32'd75000);
        wait_tick(1'b0, 32'd0);
        @(negedge clock_clk);
        check("coll_idle_next", pulse_time, 32'd75500);
        wait_tick(1'b1, 32'd74000);
        @(negedge clock_clk);
        check("coll_ramp_tick", pulse_time, 32'd76000);
        wait_tick(1'b0, 32'd0);
        @(negedge clock_clk);
        check("coll_ramp_next", pulse_time, 32'd75500);

        // Asynchronous reset mid-ramp
        #1 reset = 1'b1;
        #1;
        check("async_rst_pulse", pulse_time, 32'd75000);
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clock_clk); #1 reset = 1'b0;

        repeat (3) @(posedge clock_clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
